// File: rtl/parametrized_microcoded_processor_pkg.sv
// rtl/parametrized_microcoded_processor_pkg.sv - opcodes, FSM states and flag bit positions
package parametrized_microcoded_processor_pkg;

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b0001;
  localparam logic [3:0] OP_OR     = 4'b0010;
  localparam logic [3:0] OP_ADD    = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0100;
  localparam logic [3:0] OP_NOT_A  = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0111;
  localparam logic [3:0] OP_MUL    = 4'b1100;
  localparam logic [3:0] OP_DIV    = 4'b1101;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ITER, S_DONE, S_HOLD} state_t;

  localparam int FLAG_CARRY       = 0;
  localparam int FLAG_ZERO        = 1;
  localparam int FLAG_OVERFLOW    = 2;
  localparam int FLAG_DIV_BY_ZERO = 3;
  localparam int FLAG_ILLEGAL     = 4;
  localparam int FLAG_COUNT       = 5;

  function automatic logic is_iterative(input logic [3:0] op, input logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/parametrized_microcoded_processor_if.sv
// rtl/parametrized_microcoded_processor_if.sv - start/operand/result bundle of the processor
interface parametrized_microcoded_processor_if #(parameter int WIDTH = 8);
  logic             GO_BAR;
  logic [3:0]       OPCODE;
  logic [WIDTH-1:0] DATA_IN_A;
  logic [WIDTH-1:0] DATA_IN_B;
  logic [WIDTH-1:0] DATA_OUT;
  logic [WIDTH-1:0] DATA_OUT_HI;
  logic             BUSY;
  logic             DONE;
  logic             CARRY;
  logic             ZERO;
  logic             OVERFLOW;
  logic             DIV_BY_ZERO;
  logic             ILLEGAL;

  modport master (
    output GO_BAR, OPCODE, DATA_IN_A, DATA_IN_B,
    input  DATA_OUT, DATA_OUT_HI, BUSY, DONE, CARRY, ZERO, OVERFLOW, DIV_BY_ZERO, ILLEGAL
  );

  modport slave (
    input  GO_BAR, OPCODE, DATA_IN_A, DATA_IN_B,
    output DATA_OUT, DATA_OUT_HI, BUSY, DONE, CARRY, ZERO, OVERFLOW, DIV_BY_ZERO, ILLEGAL
  );
endinterface

// File: rtl/parametrized_microcoded_processor_mul_div.sv
// rtl/parametrized_microcoded_processor_mul_div.sv - iterative shift-add multiplier / restoring divider
module mul_div_iterative_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             is_mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic             mul_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH:0]   div_diff;
  logic             div_fit;

  // {hi,lo} is the product accumulator for MUL and {remainder,quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd} : '0);
    div_rem  = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd};
    div_fit  = div_rem >= {1'b0, opnd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mul_q <= 1'b0;
      opnd  <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      mul_q <= is_mul;
      opnd  <= is_mul ? a : b;
      lo_q  <= is_mul ? b : a;
      hi_q  <= '0;
    end else if (step && cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (mul_q) begin
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_q <= div_fit ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], div_fit};
      end
    end
  end

  assign last = (cnt == CW'(1));
  assign lo   = lo_q;
  assign hi   = hi_q;
endmodule

// File: rtl/parametrized_microcoded_processor.sv
// rtl/parametrized_microcoded_processor.sv - FSM-sequenced ALU with iterative MUL/DIV
module parametrized_microcoded_processor
  import parametrized_microcoded_processor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                          SYSTEM_CLK,
  input logic                          RESET,
  parametrized_microcoded_processor_if.slave bus
);
  state_t                state;
  logic [3:0]            op_q;
  logic [WIDTH-1:0]      a_q, b_q, lo_q, hi_q;
  logic [FLAG_COUNT-1:0] flags_q;
  logic                  busy_q, done_q;

  logic [WIDTH-1:0]      unit_lo, unit_hi;
  logic                  unit_last;
  logic [WIDTH-1:0]      fin_lo, fin_hi;
  logic [FLAG_COUNT-1:0] fin_flags;
  logic [WIDTH:0]        add_sum;
  logic [WIDTH-1:0]      sub_diff;

  mul_div_iterative_unit #(.WIDTH(WIDTH)) u_mul_div (
    .clk    (SYSTEM_CLK),
    .rst    (RESET),
    .start  (state == S_EXEC),
    .step   (state == S_ITER),
    .is_mul (op_q == OP_MUL),
    .a      (a_q),
    .b      (b_q),
    .last   (unit_last),
    .lo     (unit_lo),
    .hi     (unit_hi)
  );

  // Final result for the captured op; only latched in S_DONE so outputs change with the DONE pulse
  always_comb begin
    fin_lo    = '0;
    fin_hi    = '0;
    fin_flags = '0;
    add_sum   = {1'b0, a_q} + {1'b0, b_q};
    sub_diff  = a_q - b_q;
    case (op_q)
      OP_PASS_A: fin_lo = a_q;
      OP_AND:    fin_lo = a_q & b_q;
      OP_OR:     fin_lo = a_q | b_q;
      OP_XOR:    fin_lo = a_q ^ b_q;
      OP_NOT_A:  fin_lo = ~a_q;
      OP_ADD: begin
        fin_lo                  = add_sum[WIDTH-1:0];
        fin_flags[FLAG_CARRY]    = add_sum[WIDTH];
        fin_flags[FLAG_OVERFLOW] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        fin_lo                  = sub_diff;
        fin_flags[FLAG_CARRY]    = a_q < b_q;
        fin_flags[FLAG_OVERFLOW] = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        fin_lo                = unit_lo;
        fin_hi                = unit_hi;
        fin_flags[FLAG_CARRY] = |unit_hi;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          fin_lo                      = '1;
          fin_hi                      = a_q;
          fin_flags[FLAG_DIV_BY_ZERO] = 1'b1;
        end else begin
          fin_lo = unit_lo;
          fin_hi = unit_hi;
        end
      end
      default: fin_flags[FLAG_ILLEGAL] = 1'b1;
    endcase
    if (op_q == OP_MUL)
      fin_flags[FLAG_ZERO] = ({unit_hi, unit_lo} == '0);
    else
      fin_flags[FLAG_ZERO] = !fin_flags[FLAG_ILLEGAL] && (fin_lo == '0);
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (!bus.GO_BAR) begin
          op_q   <= bus.OPCODE;
          a_q    <= bus.DATA_IN_A;
          b_q    <= bus.DATA_IN_B;
          busy_q <= 1'b1;
          state  <= S_EXEC;
        end
        S_EXEC: state <= is_iterative(op_q, b_q == '0) ? S_ITER : S_DONE;
        S_ITER: if (unit_last) state <= S_DONE;
        S_DONE: begin
          lo_q    <= fin_lo;
          hi_q    <= fin_hi;
          flags_q <= fin_flags;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state   <= S_HOLD;
        end
        S_HOLD: if (bus.GO_BAR) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.DATA_OUT    = lo_q;
  assign bus.DATA_OUT_HI = hi_q;
  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.CARRY       = flags_q[FLAG_CARRY];
  assign bus.ZERO        = flags_q[FLAG_ZERO];
  assign bus.OVERFLOW    = flags_q[FLAG_OVERFLOW];
  assign bus.DIV_BY_ZERO = flags_q[FLAG_DIV_BY_ZERO];
  assign bus.ILLEGAL     = flags_q[FLAG_ILLEGAL];
endmodule

// File: tb/tb_parametrized_microcoded_processor.sv
// tb/tb_parametrized_microcoded_processor.sv - randomized bench against an arithmetic reference model
module tb_parametrized_microcoded_processor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  parametrized_microcoded_processor_if #(.WIDTH(8))  if8();
  parametrized_microcoded_processor_if #(.WIDTH(16)) if16();

  parametrized_microcoded_processor #(.WIDTH(8)) dut8 (
    .SYSTEM_CLK (clk),
    .RESET      (rst),
    .bus        (if8)
  );

  parametrized_microcoded_processor #(.WIDTH(16)) dut16 (
    .SYSTEM_CLK (clk),
    .RESET      (rst),
    .bus        (if16)
  );

  always #5 clk = ~clk;

  logic [63:0] obs_lo, obs_hi;
  logic [4:0]  obs_flags;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: flags packed as {carry, zero, overflow, div_by_zero, illegal}
  function automatic void model(input int w, input logic [3:0] op, input longint unsigned a, input longint unsigned b,
                                output longint unsigned lo, output longint unsigned hi,
                                output logic [4:0] flags, output int lat);
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned p;
    logic c = 0, z = 0, v = 0, dz = 0, il = 0;
    logic sa = a[w-1];
    logic sb = b[w-1];
    lo = 0; hi = 0; lat = 2;
    case (op)
      4'd0:  lo = a;
      4'd1:  lo = a & b;
      4'd2:  lo = a | b;
      4'd4:  lo = a ^ b;
      4'd5:  lo = ~a & m;
      4'd3: begin
        p = a + b; lo = p & m; c = (p > m);
        v = (sa == sb) && (lo[w-1] != sa);
      end
      4'd7: begin
        lo = (a - b) & m; c = (a < b);
        v = (sa != sb) && (lo[w-1] != sa);
      end
      4'd12: begin
        p = a * b; lo = p & m; hi = p >> w; c = (hi != 0); lat = w + 2;
      end
      4'd13: begin
        if (b == 0) begin lo = m; hi = a; dz = 1; end
        else begin lo = a / b; hi = a % b; lat = w + 2; end
      end
      default: il = 1;
    endcase
    if (op == 4'd12) z = ((a * b) == 0);
    else z = !il && (lo == 0);
    flags = {c, z, v, dz, il};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    longint unsigned elo, ehi;
    logic [4:0] eflags;
    int elat, n;
    model(8, op, a, b, elo, ehi, eflags, elat);
    if8.OPCODE = op; if8.DATA_IN_A = a; if8.DATA_IN_B = b; if8.GO_BAR = 1'b0;
    @(posedge clk); #1;
    if8.GO_BAR = 1'b1;
    if8.OPCODE = 4'($urandom); if8.DATA_IN_A = 8'($urandom); if8.DATA_IN_B = 8'($urandom);
    check({tag, "_busy"}, if8.BUSY, 1);
    n = 0;
    while (!if8.DONE && n < 64) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_busy_at_done"}, if8.BUSY, 0);
    check({tag, "_lo"}, if8.DATA_OUT, elo);
    check({tag, "_hi"}, if8.DATA_OUT_HI, ehi);
    obs_flags = {if8.CARRY, if8.ZERO, if8.OVERFLOW, if8.DIV_BY_ZERO, if8.ILLEGAL};
    check({tag, "_flags"}, obs_flags, eflags);
    obs_lo = if8.DATA_OUT; obs_hi = if8.DATA_OUT_HI;
    @(posedge clk); #1;
    check({tag, "_pulse"}, if8.DONE, 0);
    check({tag, "_held"}, if8.DATA_OUT, elo);
  endtask

  initial begin
    logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'hC, 4'hD, 4'h6, 4'hE, 4'hF};
    int pulses, n;
    if8.GO_BAR = 1'b1; if8.OPCODE = '0; if8.DATA_IN_A = '0; if8.DATA_IN_B = '0;
    if16.GO_BAR = 1'b1; if16.OPCODE = '0; if16.DATA_IN_A = '0; if16.DATA_IN_B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {if8.DATA_OUT, if8.DATA_OUT_HI}, 0);
    check("rst_ctl", {if8.BUSY, if8.DONE, if8.CARRY, if8.ZERO, if8.OVERFLOW, if8.DIV_BY_ZERO, if8.ILLEGAL}, 0);
    rst = 1'b0;

    run_op("add", 4'h3, 8'h31, 8'h05);
    check("add_spec", {obs_lo[7:0], obs_flags[4]}, {8'h36, 1'b0});
    run_op("sub1", 4'h7, 8'h05, 8'h31);
    check("sub1_spec", {obs_lo[7:0], obs_flags[4], obs_flags[2]}, {8'hD4, 1'b1, 1'b0});
    run_op("sub2", 4'h7, 8'h80, 8'h01);
    check("sub2_spec", {obs_lo[7:0], obs_flags[2]}, {8'h7F, 1'b1});
    run_op("mul1", 4'hC, 8'h31, 8'h05);
    check("mul1_spec", {obs_hi[7:0], obs_lo[7:0]}, 16'h00F5);
    run_op("mul2", 4'hC, 8'hFF, 8'hFF);
    check("mul2_spec", {obs_hi[7:0], obs_lo[7:0], obs_flags[4]}, {16'hFE01, 1'b1});
    run_op("div1", 4'hD, 8'h31, 8'h05);
    check("div1_spec", {obs_lo[7:0], obs_hi[7:0]}, 16'h0904);
    run_op("div0", 4'hD, 8'h31, 8'h00);
    check("div0_spec", {obs_lo[7:0], obs_hi[7:0], obs_flags[1]}, {16'hFF31, 1'b1});
    run_op("ill", 4'hF, 8'h12, 8'h34);
    check("ill_spec", {obs_lo[7:0], obs_flags}, {8'h00, 5'b00001});

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      run_op("rnd", ops[$urandom_range(0, 11)], 8'($urandom), b);
    end

    // GO_BAR held low must yield a single operation
    if8.OPCODE = 4'h3; if8.DATA_IN_A = 8'h10; if8.DATA_IN_B = 8'h20; if8.GO_BAR = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (if8.DONE) pulses++;
    end
    check("held_low_pulses", pulses, 1);
    check("held_low_lo", if8.DATA_OUT, 8'h30);
    if8.GO_BAR = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Abort a MUL partway through its iterations
    if8.OPCODE = 4'hC; if8.DATA_IN_A = 8'hFF; if8.DATA_IN_B = 8'hFF; if8.GO_BAR = 1'b0;
    @(posedge clk); #1;
    if8.GO_BAR = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out", {if8.DATA_OUT, if8.DATA_OUT_HI}, 0);
    check("abort_ctl", {if8.BUSY, if8.DONE, if8.CARRY, if8.ZERO, if8.OVERFLOW, if8.DIV_BY_ZERO, if8.ILLEGAL}, 0);
    rst = 1'b0;
    run_op("post_rst_add", 4'h3, 8'h31, 8'h05);

    // 16-bit instance
    if16.OPCODE = 4'hC; if16.DATA_IN_A = 16'hFFFF; if16.DATA_IN_B = 16'h0002; if16.GO_BAR = 1'b0;
    @(posedge clk); #1;
    if16.GO_BAR = 1'b1;
    n = 0;
    while (!if16.DONE && n < 64) begin
      @(posedge clk); #1; n++;
    end
    check("w16_mul_lat", n, 18);
    check("w16_mul", {if16.DATA_OUT_HI, if16.DATA_OUT}, 32'h0001FFFE);
    check("w16_carry", if16.CARRY, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
